axi_llc_burst_joiner: RTL and testbench
=======================================

Name: axi_llc_burst_joiner

Overview:
- Merges per-cache-line write completions back into a single AXI B response per original AW burst.
- Sits at the response side of the LLC, after the write unit and before the slave-port B channel.
- Upstream of the LLC, each AW burst is split into line-sized descriptors. Each descriptor carries `x_last=1` only on its final piece.
- Descriptor completions arrive in issue order. The block accumulates them and emits one B beat carrying the merged response once the `x_last` piece is absorbed.

Parameters:
- IdWidth, 6, width of AXI ID.
- UserWidth, 4, width of B user field; carries the partition id.
- FifoDepth, 2, depth of the merged-response output FIFO; must be ≥1.
- CntWidth, 8, width of the piece counter; saturates.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- piece_valid_i  in  1  descriptor completion valid.
- piece_ready_o  out  1  descriptor completion accepted.
- piece_id_i  in  IdWidth  AXI ID of the descriptor.
- piece_user_i  in  UserWidth  partition id of the descriptor.
- piece_resp_i  in  2  response of this piece.
- piece_last_i  in  1  `x_last` of the descriptor.
- b_valid_o  out  1  merged B valid.
- b_ready_i  in  1  merged B ready.
- b_id_o  out  IdWidth  B ID.
- b_user_o  out  UserWidth  B user.
- b_resp_o  out  2  merged response.
- b_pieces_o  out  CntWidth  number of pieces merged into this B; sideband for perf counters.
- id_err_o  out  1  one-cycle pulse: a piece's ID/user differs from the first piece of the same burst.
- busy_o  out  1  accumulator holds a partial burst.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - `rst_i` is synchronous and active-high. It clears all state on the next edge and overrides any concurrent handshake.
- Reset values:
  - `piece_ready_o=1`, `b_valid_o=0`, `id_err_o=0`, `busy_o=0`.
  - `b_id_o`, `b_user_o`, `b_resp_o` and `b_pieces_o` are all 0.
- Accumulator states: IDLE and ACCUM.
  - IDLE, piece accepted with `last=0` → ACCUM. Latch id, user, resp and cnt=1.
  - IDLE, piece accepted with `last=1` → stay IDLE. Push {id, user, resp, cnt=1} into the FIFO directly.
  - ACCUM, piece accepted with `last=0` → stay ACCUM. Merge resp, cnt += 1 (saturates at 2^CntWidth−1).
  - ACCUM, piece accepted with `last=1` → IDLE. Push the merged entry (including this piece) into the FIFO.
- Handshake:
  - A piece is accepted when `piece_valid_i && piece_ready_o`.
  - `piece_ready_o = !fifo_full`, registered-state only; no combinational path from `piece_valid_i`.
  - Non-last pieces are also stalled while the FIFO is full (simplicity).
  - `piece_*` inputs must be held stable while valid is high and ready is low.
- Response merge rule, over all pieces of a burst:
  - Any DECERR → DECERR.
  - Else any SLVERR → SLVERR.
  - Else all EXOKAY → EXOKAY.
  - Else (mixed OKAY/EXOKAY, or all OKAY) → OKAY.
  - Implementation: track flag `err_max` (2 bits) and flag `all_ex`.
- ID check:
  - In ACCUM, an accepted piece whose id/user differs from the latched values asserts `id_err_o` for exactly one cycle (the cycle after acceptance).
  - The latched id/user are kept; merging continues.
- Output FIFO:
  - FifoDepth entries, first-word fall-through.
  - Latency: last piece accepted in cycle t → `b_valid_o=1` in cycle t+1 if the FIFO was empty.
  - `b_valid_o` stays high, with B fields stable, until `b_ready_i`.
  - Push and pop in the same cycle with the FIFO full: not possible, because ready was low. Push and pop when not full are both honoured.
  - FIFO pointers wrap modulo FifoDepth. full/empty are derived from an occupancy counter of width `$clog2(FifoDepth+1)`.
- `busy_o = (state==ACCUM)`.
- Reset mid-burst: the partial accumulation and FIFO contents are discarded. No B is emitted for them.

Test Plan:
- Single piece, id=5, resp=OKAY, last=1 → one cycle later B id=5, resp=OKAY, pieces=1; busy_o stays 0.
- 4 pieces id=3, resps OKAY, SLVERR, OKAY, DECERR, last on the 4th → exactly one B: resp=DECERR, pieces=4; busy_o high from after piece 1 until piece 4 is accepted.
- 3 pieces all EXOKAY → resp=EXOKAY; repeat with the 2nd piece OKAY → resp=OKAY.
- `b_ready_i=0`, three single-piece bursts, FifoDepth=2 → `piece_ready_o` drops after 2 pushes. Then raise `b_ready_i` → B ids come out in order and the third piece is accepted the cycle after the first pop.
- 2-piece burst, 1st id=1, 2nd id=2 → `id_err_o` pulses one cycle; B id=1, pieces=2.
- Assert `rst_i` after 2 of 3 pieces are accepted → next cycle `busy_o=0` and `b_valid_o=0`; a subsequent single-piece burst yields B with pieces=1.

Source files
------------

// File: rtl/axi_llc_burst_joiner.sv
// Joins per-cache-line write completions into one merged AXI B beat per burst.
// state    | meaning
// IDLE     | no partial burst held; next piece starts a new burst
// ACCUM    | first piece(s) of a burst absorbed, waiting for the x_last piece
module axi_llc_burst_joiner #(
    parameter int IdWidth   = 6,
    parameter int UserWidth = 4,
    parameter int FifoDepth = 2,
    parameter int CntWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 piece_valid_i,
    output logic                 piece_ready_o,
    input  logic [IdWidth-1:0]   piece_id_i,
    input  logic [UserWidth-1:0] piece_user_i,
    input  logic [1:0]           piece_resp_i,
    input  logic                 piece_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [UserWidth-1:0] b_user_o,
    output logic [1:0]           b_resp_o,
    output logic [CntWidth-1:0]  b_pieces_o,
    output logic                 id_err_o,
    output logic                 busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW = $clog2(FifoDepth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FifoDepth - 1);
    localparam logic [OccW-1:0] FullOcc  = OccW'(FifoDepth);
    localparam logic [CntWidth-1:0] CntMax = '1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    logic [0:0]           r_state;
    logic [IdWidth-1:0]   r_id;
    logic [UserWidth-1:0] r_user;
    logic [1:0]           r_err_max;
    logic                 r_all_ex;
    logic [CntWidth-1:0]  r_cnt;
    logic                 r_id_err;

    logic [IdWidth-1:0]   r_fifo_id     [FifoDepth];
    logic [UserWidth-1:0] r_fifo_user   [FifoDepth];
    logic [1:0]           r_fifo_resp   [FifoDepth];
    logic [CntWidth-1:0]  r_fifo_pieces [FifoDepth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [OccW-1:0]      r_occ;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_piece_err;
    logic [1:0]           w_err_max;
    logic                 w_all_ex;
    logic [CntWidth-1:0]  w_cnt;
    logic [1:0]           w_merged_resp;
    logic [IdWidth-1:0]   w_push_id;
    logic [UserWidth-1:0] w_push_user;
    logic                 w_id_mismatch;

    function automatic logic [PtrW-1:0] f_next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign w_full        = (r_occ == FullOcc);
    assign w_empty       = (r_occ == '0);
    assign piece_ready_o = !w_full;
    assign w_accept      = piece_valid_i && piece_ready_o;
    assign w_push        = w_accept && piece_last_i;
    assign w_pop         = b_valid_o && b_ready_i;

    // Only SLVERR/DECERR contribute to err_max; they encode in ascending severity.
    assign w_piece_err   = piece_resp_i[1] ? piece_resp_i : RESP_OKAY;
    assign w_id_mismatch = (piece_id_i != r_id) || (piece_user_i != r_user);

    always_comb begin
        w_err_max   = w_piece_err;
        w_all_ex    = (piece_resp_i == RESP_EXOKAY);
        w_cnt       = CntWidth'(1);
        w_push_id   = piece_id_i;
        w_push_user = piece_user_i;
        if (r_state == ST_ACCUM) begin
            w_err_max   = (w_piece_err > r_err_max) ? w_piece_err : r_err_max;
            w_all_ex    = r_all_ex && (piece_resp_i == RESP_EXOKAY);
            w_cnt       = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;
            w_push_id   = r_id;
            w_push_user = r_user;
        end
    end

    assign w_merged_resp = (w_err_max != RESP_OKAY) ? w_err_max :
                           (w_all_ex ? RESP_EXOKAY : RESP_OKAY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_user    <= '0;
            r_err_max <= '0;
            r_all_ex  <= 1'b0;
            r_cnt     <= '0;
            r_id_err  <= 1'b0;
        end else begin
            r_id_err <= w_accept && (r_state == ST_ACCUM) && w_id_mismatch;
            if (w_accept) begin
                if (piece_last_i) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state   <= ST_ACCUM;
                    r_err_max <= w_err_max;
                    r_all_ex  <= w_all_ex;
                    r_cnt     <= w_cnt;
                    // The first piece defines the burst identity; later mismatches only flag.
                    if (r_state == ST_IDLE) begin
                        r_id   <= piece_id_i;
                        r_user <= piece_user_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wptr]     <= w_push_id;
            r_fifo_user[r_wptr]   <= w_push_user;
            r_fifo_resp[r_wptr]   <= w_merged_resp;
            r_fifo_pieces[r_wptr] <= w_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // Fields read as zero while empty so stale or unwritten storage never shows.
    assign b_valid_o  = !w_empty;
    assign b_id_o     = w_empty ? '0 : r_fifo_id[r_rptr];
    assign b_user_o   = w_empty ? '0 : r_fifo_user[r_rptr];
    assign b_resp_o   = w_empty ? '0 : r_fifo_resp[r_rptr];
    assign b_pieces_o = w_empty ? '0 : r_fifo_pieces[r_rptr];
    assign id_err_o   = r_id_err;
    assign busy_o     = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_axi_llc_burst_joiner.sv
// Bench for axi_llc_burst_joiner: burst-level reference model plus directed scenarios.
module tb_axi_llc_burst_joiner;

    localparam int IdWidth   = 6;
    localparam int UserWidth = 4;
    localparam int FifoDepth = 2;
    localparam int CntWidth  = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 piece_valid_i;
    logic                 piece_ready_o;
    logic [IdWidth-1:0]   piece_id_i;
    logic [UserWidth-1:0] piece_user_i;
    logic [1:0]           piece_resp_i;
    logic                 piece_last_i;
    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [UserWidth-1:0] b_user_o;
    logic [1:0]           b_resp_o;
    logic [CntWidth-1:0]  b_pieces_o;
    logic                 id_err_o;
    logic                 busy_o;

    axi_llc_burst_joiner #(
        .IdWidth(IdWidth), .UserWidth(UserWidth), .FifoDepth(FifoDepth), .CntWidth(CntWidth)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .piece_valid_i(piece_valid_i), .piece_ready_o(piece_ready_o),
        .piece_id_i(piece_id_i), .piece_user_i(piece_user_i),
        .piece_resp_i(piece_resp_i), .piece_last_i(piece_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .b_id_o(b_id_o), .b_user_o(b_user_o), .b_resp_o(b_resp_o),
        .b_pieces_o(b_pieces_o), .id_err_o(id_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [UserWidth-1:0] user;
        logic [1:0]           resp;
        logic [CntWidth-1:0]  pieces;
    } b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [UserWidth-1:0] user;
        logic [1:0]           resp;
    } piece_t;

    int     n_checks = 0;
    int     n_errors = 0;
    b_t     exp_q[$];
    piece_t cur[$];
    b_t     popped[$];
    logic   exp_id_err = 1'b0;
    logic   started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst response from the whole list of piece responses.
    function automatic b_t merge_burst(input piece_t ps[$]);
        b_t  r;
        bit  any_dec = 0, any_slv = 0, all_ex = 1;
        foreach (ps[i]) begin
            if (ps[i].resp == 2'd3) any_dec = 1;
            if (ps[i].resp == 2'd2) any_slv = 1;
            if (ps[i].resp != 2'd1) all_ex = 0;
        end
        r.id     = ps[0].id;
        r.user   = ps[0].user;
        r.resp   = any_dec ? 2'd3 : any_slv ? 2'd2 : all_ex ? 2'd1 : 2'd0;
        r.pieces = (ps.size() > 255) ? 8'd255 : CntWidth'(ps.size());
        return r;
    endfunction

    always @(posedge clk_i) begin
        started <= 1'b1;
        if (rst_i) begin
            exp_q.delete();
            cur.delete();
            exp_id_err <= 1'b0;
        end else begin
            if (b_valid_o && b_ready_i) begin
                popped.push_back(b_t'{b_id_o, b_user_o, b_resp_o, b_pieces_o});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            exp_id_err <= 1'b0;
            if (piece_valid_i && piece_ready_o) begin
                if (cur.size() > 0 && (piece_id_i != cur[0].id || piece_user_i != cur[0].user))
                    exp_id_err <= 1'b1;
                cur.push_back(piece_t'{piece_id_i, piece_user_i, piece_resp_i});
                if (piece_last_i) begin
                    exp_q.push_back(merge_burst(cur));
                    cur.delete();
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (started) begin
            check("piece_ready", 32'(piece_ready_o), 32'(exp_q.size() < FifoDepth));
            check("b_valid", 32'(b_valid_o), 32'(exp_q.size() != 0));
            check("id_err", 32'(id_err_o), 32'(exp_id_err));
            check("busy", 32'(busy_o), 32'(cur.size() != 0));
            if (exp_q.size() != 0) begin
                check("b_id", 32'(b_id_o), 32'(exp_q[0].id));
                check("b_user", 32'(b_user_o), 32'(exp_q[0].user));
                check("b_resp", 32'(b_resp_o), 32'(exp_q[0].resp));
                check("b_pieces", 32'(b_pieces_o), 32'(exp_q[0].pieces));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_piece(input int id, input int user, input int resp, input bit last);
        bit acc = 0;
        int n = 0;
        piece_valid_i = 1'b1;
        piece_id_i    = IdWidth'(id);
        piece_user_i  = UserWidth'(user);
        piece_resp_i  = 2'(resp);
        piece_last_i  = last;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            if (piece_ready_o) acc = 1;
            @(posedge clk_i);
            n++;
        end
        #1 piece_valid_i = 1'b0;
        if (!acc) begin
            n_errors++;
            $display("FAIL accept_timeout: piece id %0d never accepted", id);
        end
    endtask

    task automatic check_popped(input string name, input int idx, input b_t exp);
        if (idx >= popped.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: only %0d B beats seen, expected beat %0d", name, popped.size(), idx);
        end else begin
            check({name, "_id"}, 32'(popped[idx].id), 32'(exp.id));
            check({name, "_resp"}, 32'(popped[idx].resp), 32'(exp.resp));
            check({name, "_pieces"}, 32'(popped[idx].pieces), 32'(exp.pieces));
        end
    endtask

    int base;

    initial begin
        rst_i = 1'b1;
        piece_valid_i = 1'b0;
        piece_id_i = '0;
        piece_user_i = '0;
        piece_resp_i = '0;
        piece_last_i = 1'b0;
        b_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(piece_ready_o), 32'd1);
        check("rst_b_valid", 32'(b_valid_o), 32'd0);
        check("rst_id_err", 32'(id_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_b_fields", {b_id_o, b_user_o, b_resp_o, b_pieces_o}, 32'd0);
        @(posedge clk_i); #1;

        // single piece burst
        base = popped.size();
        send_piece(5, 1, 0, 1);
        @(negedge clk_i);
        check("single_b_valid_t1", 32'(b_valid_o), 32'd1);
        check("single_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i); #1;
        check_popped("single", base, b_t'{6'd5, 4'd1, 2'd0, 8'd1});

        // four pieces, worst response wins
        base = popped.size();
        send_piece(3, 2, 0, 0);
        @(negedge clk_i);
        check("four_busy_after_p1", 32'(busy_o), 32'd1);
        @(posedge clk_i); #1;
        send_piece(3, 2, 2, 0);
        send_piece(3, 2, 0, 0);
        send_piece(3, 2, 3, 1);
        @(negedge clk_i);
        check("four_busy_after_p4", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i); #1;
        check("four_one_b", 32'(popped.size() - base), 32'd1);
        check_popped("four", base, b_t'{6'd3, 4'd2, 2'd3, 8'd4});

        // EXOKAY only when every piece is EXOKAY
        base = popped.size();
        send_piece(7, 3, 1, 0);
        send_piece(7, 3, 1, 0);
        send_piece(7, 3, 1, 1);
        send_piece(8, 3, 1, 0);
        send_piece(8, 3, 0, 0);
        send_piece(8, 3, 1, 1);
        repeat (3) @(posedge clk_i); #1;
        check_popped("allex", base, b_t'{6'd7, 4'd3, 2'd1, 8'd3});
        check_popped("mixex", base + 1, b_t'{6'd8, 4'd3, 2'd0, 8'd3});

        // backpressure fills the FIFO, third piece waits for first pop
        base = popped.size();
        b_ready_i = 1'b0;
        send_piece(10, 0, 0, 1);
        send_piece(11, 0, 2, 1);
        @(negedge clk_i);
        check("bp_ready_low", 32'(piece_ready_o), 32'd0);
        @(posedge clk_i); #1;
        fork
            send_piece(12, 0, 1, 1);
            begin
                repeat (3) @(posedge clk_i);
                #1 b_ready_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk_i); #1;
        check_popped("bp0", base, b_t'{6'd10, 4'd0, 2'd0, 8'd1});
        check_popped("bp1", base + 1, b_t'{6'd11, 4'd0, 2'd2, 8'd1});
        check_popped("bp2", base + 2, b_t'{6'd12, 4'd0, 2'd1, 8'd1});

        // id mismatch inside a burst
        base = popped.size();
        send_piece(1, 4, 0, 0);
        send_piece(2, 4, 0, 1);
        @(negedge clk_i);
        check("iderr_pulse", 32'(id_err_o), 32'd1);
        @(negedge clk_i);
        check("iderr_clear", 32'(id_err_o), 32'd0);
        repeat (2) @(posedge clk_i); #1;
        check_popped("iderr", base, b_t'{6'd1, 4'd4, 2'd0, 8'd2});

        // reset mid-burst discards the partial accumulation
        send_piece(20, 5, 2, 0);
        send_piece(20, 5, 0, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_b_valid", 32'(b_valid_o), 32'd0);
        @(posedge clk_i); #1;
        base = popped.size();
        send_piece(9, 6, 0, 1);
        repeat (3) @(posedge clk_i); #1;
        check("midrst_one_b", 32'(popped.size() - base), 32'd1);
        check_popped("midrst", base, b_t'{6'd9, 4'd6, 2'd0, 8'd1});

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
